// File: rtl/timestamp_capture.sv
// Event timestamp capture: synchronises evt_in, detects the selected edge and
// queues the current count value in a small FIFO drained via valid/ready.
module timestamp_capture #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned EDGE_RISE = 1
) (
    input  logic                      clk,
    input  logic                      rst_async,
    input  logic [15:0]               count,
    input  logic                      evt_in,
    output logic [15:0]               ts_data,
    output logic                      ts_valid,
    input  logic                      ts_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_cnt,
    input  logic                      ovf_clr
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam logic        ACTIVE = (EDGE_RISE != 0);

    logic            r_s1, r_s2, r_s3;
    logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [15:0]     r_mem [DEPTH];
    logic [15:0]     r_data;
    logic            r_valid;
    logic [PW-1:0]   r_level;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;

    logic            w_edge;
    logic            w_full, w_empty;
    logic            w_pop, w_push, w_drop;
    logic [PW-1:0]   w_wr_nxt, w_rd_nxt;
    logic [15:0]     w_head_nxt;

    // Metastability guard (s1/s2) plus previous-value flop (s3)
    always_ff @(posedge clk) begin
        if (rst_async) begin
            r_s1 <= ACTIVE;
            r_s2 <= ACTIVE;
            r_s3 <= ACTIVE;
        end else begin
            r_s1 <= evt_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_comb begin
        w_edge = 1'b0;
        if (ACTIVE) w_edge = r_s2 & ~r_s3;
        else        w_edge = ~r_s2 & r_s3;
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = ~w_empty & ts_ready;
    assign w_push  = w_edge & (~w_full | w_pop);
    assign w_drop  = w_edge & w_full & ~w_pop;

    assign w_wr_nxt = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
    assign w_rd_nxt = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;

    // Head after this edge: a push into the slot that becomes the head forwards count
    always_comb begin
        w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
        if (w_push && (r_wr_ptr[AW-1:0] == w_rd_nxt[AW-1:0]))
            w_head_nxt = count;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= count;
    end

    always_ff @(posedge clk) begin
        if (rst_async) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_level  <= w_wr_nxt - w_rd_nxt;
            r_valid  <= (w_wr_nxt != w_rd_nxt);
            r_data   <= w_head_nxt;
        end
    end

    // A drop in the same cycle as a clear wins and restarts the count at 1
    always_ff @(posedge clk) begin
        if (rst_async) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr)                  r_drop_cnt <= 8'd1;
            else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign ts_data  = r_data;
    assign ts_valid = r_valid;
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed self-checking bench for timestamp_capture (DEPTH=4, rising edge).
module tb_timestamp_capture;

    logic        clk = 1'b0;
    logic        rst_async = 1'b1;
    logic [15:0] count = '0;
    logic        evt_in = 1'b0;
    logic [15:0] ts_data;
    logic        ts_valid;
    logic        ts_ready = 1'b0;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        ovf_clr = 1'b0;

    logic        cnt_ld = 1'b0;
    logic [15:0] cnt_val = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];

    timestamp_capture #(.DEPTH(4), .EDGE_RISE(1)) dut (
        .clk(clk), .rst_async(rst_async), .count(count), .evt_in(evt_in),
        .ts_data(ts_data), .ts_valid(ts_valid), .ts_ready(ts_ready),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream free-running counter
    always @(posedge clk) count <= cnt_ld ? cnt_val : count + 16'd1;

    task automatic tick();
        @(negedge clk);
    endtask

    // One event: high 2 cycles, low 2 cycles; captured value is count two edges later
    task automatic pulse(input bit record);
        if (record) exp_q.push_back(16'(count + 16'd2));
        evt_in = 1'b1; tick(); tick();
        evt_in = 1'b0; tick(); tick();
    endtask

    task automatic test_reset();
        rst_async = 1'b1; evt_in = 1'b0;
        repeat (3) tick();
        rst_async = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_vec++;
            if (ts_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 ||
                drop_cnt !== 8'd0 || ts_data !== 16'd0) begin
                n_err++;
                $display("FAIL reset_idle cyc %0d: valid=%b level=%0d ovf=%b drop=%0d data=%h, want 0/0/0/0/0000",
                         i, ts_valid, level, overflow, drop_cnt, ts_data);
            end
            tick();
        end
    endtask

    task automatic test_single();
        bit found = 0;
        cnt_ld = 1'b1; cnt_val = 16'h000C; tick(); cnt_ld = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (count == 16'h0010) begin found = 1; break; end
            tick();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL single_wait: count=%h never reached 0010", count);
        end
        evt_in = 1'b1;
        tick(); tick();
        n_vec++;
        if (ts_valid !== 1'b0) begin
            n_err++; $display("FAIL single_early_valid: got %b want 0", ts_valid);
        end
        tick();
        n_vec++;
        if (ts_valid !== 1'b1 || ts_data !== 16'h0012 || level !== 3'd1) begin
            n_err++;
            $display("FAIL single_capture: valid=%b data=%h level=%0d want 1/0012/1", ts_valid, ts_data, level);
        end
        ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        n_vec++;
        if (level !== 3'd0 || ts_valid !== 1'b0) begin
            n_err++; $display("FAIL single_pop: level=%0d valid=%b want 0/0", level, ts_valid);
        end
        evt_in = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (level !== 3'd0) begin
            n_err++; $display("FAIL single_fall_ignored: level=%0d want 0", level);
        end
    endtask

    task automatic drain(input string tag, input int n);
        ts_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (ts_valid !== 1'b1 || ts_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL %s_drain[%0d]: valid=%b data=%h want 1/%h", tag, i, ts_valid, ts_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
            tick();
        end
        ts_ready = 1'b0;
        n_vec++;
        if (ts_valid !== 1'b0 || level !== 3'd0) begin
            n_err++; $display("FAIL %s_empty: valid=%b level=%0d want 0/0", tag, ts_valid, level);
        end
    endtask

    task automatic test_overflow();
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(16'(count + 16'd2));
            evt_in = 1'b1; repeat (5) tick();
            evt_in = 1'b0; repeat (5) tick();
        end
        n_vec++;
        if (level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL ovf_state: level=%0d ovf=%b drop=%0d want 4/1/2", level, overflow, drop_cnt);
        end
        drain("ovf", 4);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_vec++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++; $display("FAIL ovf_clear: ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
        end
    endtask

    task automatic test_full_pop();
        exp_q.delete();
        for (int i = 0; i < 4; i++) pulse(1'b1);
        n_vec++;
        if (level !== 3'd4) begin
            n_err++; $display("FAIL fullpop_fill: level=%0d want 4", level);
        end
        exp_q.push_back(16'(count + 16'd2));
        evt_in = 1'b1; tick(); tick();
        ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        void'(exp_q.pop_front());
        n_vec++;
        if (level !== 3'd4 || overflow !== 1'b0 || drop_cnt !== 8'd0 || ts_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL fullpop_same_cycle: level=%0d ovf=%b drop=%0d data=%h want 4/0/0/%h",
                     level, overflow, drop_cnt, ts_data, exp_q[0]);
        end
        evt_in = 1'b0; tick(); tick();
        drain("fullpop", 4);
    endtask

    task automatic test_saturate();
        exp_q.delete();
        for (int i = 0; i < 304; i++) begin
            pulse(i < 4);
            if (i == 13) begin
                n_vec++;
                if (drop_cnt !== 8'd10 || overflow !== 1'b1) begin
                    n_err++; $display("FAIL sat_partial: drop=%0d ovf=%b want 10/1", drop_cnt, overflow);
                end
            end
        end
        n_vec++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1 || level !== 3'd4) begin
            n_err++;
            $display("FAIL sat_max: drop=%0d ovf=%b level=%0d want 255/1/4", drop_cnt, overflow, level);
        end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_vec++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            n_err++; $display("FAIL sat_clear: drop=%0d ovf=%b want 0/0", drop_cnt, overflow);
        end
        evt_in = 1'b1; tick(); tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_vec++;
        if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
            n_err++; $display("FAIL clr_vs_drop: drop=%0d ovf=%b want 1/1", drop_cnt, overflow);
        end
        evt_in = 1'b0; tick(); tick();
        drain("sat", 4);
    endtask

    task automatic test_reset_mid_and_wrap();
        exp_q.delete();
        for (int i = 0; i < 3; i++) pulse(1'b0);
        n_vec++;
        if (level !== 3'd3) begin
            n_err++; $display("FAIL rst_pre_fill: level=%0d want 3", level);
        end
        evt_in = 1'b1; tick();
        rst_async = 1'b1; tick(); tick();
        rst_async = 1'b0;
        n_vec++;
        if (ts_valid !== 1'b0 || level !== 3'd0 || ts_data !== 16'd0 ||
            overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL rst_mid: valid=%b level=%0d data=%h ovf=%b drop=%0d want 0/0/0000/0/0",
                     ts_valid, level, ts_data, overflow, drop_cnt);
        end
        repeat (8) tick();
        n_vec++;
        if (ts_valid !== 1'b0 || level !== 3'd0) begin
            n_err++; $display("FAIL rst_held_evt: valid=%b level=%0d want 0/0", ts_valid, level);
        end
        evt_in = 1'b0; tick(); tick();
        cnt_ld = 1'b1; cnt_val = 16'hFFFD; tick(); cnt_ld = 1'b0;
        evt_in = 1'b1; tick(); tick();
        evt_in = 1'b0; tick(); tick();
        evt_in = 1'b1; tick(); tick();
        evt_in = 1'b0; tick(); tick();
        n_vec++;
        if (level !== 3'd2 || ts_data !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_first: level=%0d data=%h want 2/ffff", level, ts_data);
        end
        ts_ready = 1'b1; tick(); ts_ready = 1'b0;
        n_vec++;
        if (level !== 3'd1 || ts_data !== 16'h0003) begin
            n_err++; $display("FAIL wrap_second: level=%0d data=%h want 1/0003", level, ts_data);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_saturate();
        test_reset_mid_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timestamp_capture.md
# timestamp_capture

Event-timestamping stage that sits directly downstream of the 16-bit free-running counter. It consumes the counter's `count` bus and watches a single event input. On each qualifying edge it writes the current count value into a small FIFO, which a consumer drains through a valid/ready handshake. When the FIFO is full, new events are dropped and the loss is reported through a sticky overflow flag and a saturating drop counter.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `EDGE_RISE`, default 1: 1 captures on a rising edge of `evt_in`; 0 captures on a falling edge.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_async` input 1: reset, synchronous and active-high; sampled only on the rising edge of `clk`.
- `count` input 16: timestamp source, driven by the 16-bit counter in the same `clk` domain.
- `evt_in` input 1: event line, possibly asynchronous to `clk`.
- `ts_data` output 16: timestamp at the FIFO head.
- `ts_valid` output 1: FIFO non-empty.
- `ts_ready` input 1: consumer accepts the head entry.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `overflow` output 1: sticky; set when an event is dropped.
- `drop_cnt` output 8: number of dropped events, saturating at 255.
- `ovf_clr` input 1: single-cycle clear of `overflow` and `drop_cnt`.

## Operation
- Synchronizer: `evt_in` feeds a 3-flop chain s1 -> s2 -> s3. s1/s2 form the metastability guard; s3 holds the previous value.
- Edge detect: `edge = s2 & ~s3` when EDGE_RISE=1; `edge = ~s2 & s3` when EDGE_RISE=0.
- Push: on `edge`, write the value of `count` present at that clock edge to the tail.
- Pop: when `ts_valid & ts_ready`, advance the head.
- Push and pop in the same cycle are both performed:
  - When full, the pop frees a slot, the push is accepted, and `level` is unchanged.
  - When empty, only the push takes effect and `level` becomes 1. There is no bypass: `ts_valid` rises the cycle after the write.
- Drop: `edge` while full with no simultaneous pop:
  - No write and no pointer change.
  - `overflow` <= 1.
  - `drop_cnt` <= min(`drop_cnt`+1, 255).
- `ovf_clr`:
  - Alone, it sets `overflow` <= 0 and `drop_cnt` <= 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- Pointers are log2(DEPTH)+1 bits wide with natural wrap.
  - Full: MSBs differ and the low bits are equal.
  - Empty: pointers are equal.
  - `level` = wr_ptr - rd_ptr, modulo 2^(log2(DEPTH)+1).
- `ts_data` is a registered-array read at rd_ptr. It holds stable while `ts_valid` is high and `ts_ready` is low.
- Reset values:
  - Pointers = 0, `level` = 0, `ts_valid` = 0.
  - `overflow` = 0, `drop_cnt` = 0.
  - `ts_data` = 0.
  - s1/s2/s3 load the active level (1 if EDGE_RISE, else 0). An event already asserted when reset releases therefore produces no capture.
- Reset mid-operation discards all queued entries. Events in the synchronizer are lost.
- `count` wrap from 0xFFFF to 0x0000 needs no special handling; values are stored raw.

## Timing
- `evt_in` first sampled active at edge N: s1 at N, s2 at N+1, s3 at N+2.
- `edge` is high in the cycle between N+1 and N+2. The FIFO write happens at edge N+2 and stores `count` as seen at edge N+2.
- If the FIFO was empty, `ts_valid` = 1 from edge N+2; event-to-valid latency is 3 edges.
- Pop: the entry is consumed at the edge where `ts_valid & ts_ready`. The next entry appears on `ts_data` in the following cycle.
- Throughput: one push and one pop per cycle.
- Minimum event spacing: `evt_in` must hold each level for at least 2 cycles so that every edge is captured exactly once.
- `overflow`, `drop_cnt` and `level` update at the same edge as the push, pop or drop that changes them.

## Test plan
- Reset, then hold `evt_in` at 0 and run the counter -> `ts_valid` = 0, `level` = 0, `overflow` = 0 and `drop_cnt` = 0 throughout.
- Single event, EDGE_RISE=1, `evt_in` high at the edge where count = 0x0010 -> one entry `ts_data` = 0x0012, `ts_valid` high from that edge, `level` = 1. Pop with `ts_ready` = 1 -> `level` = 0 next cycle.
- `ts_ready` = 0 and 6 events spaced 10 cycles apart with DEPTH=4 -> entries 1-4 stored in order, `overflow` = 1, `drop_cnt` = 2. Drain gives 4 in-order timestamps, then `ts_valid` = 0.
- FIFO full, event edge coinciding with a pop -> no drop, `level` stays 4, and the new timestamp appears last.
- 300 drops, then `ovf_clr` -> `drop_cnt` saturates at 255, then clears to 0. `ovf_clr` in the same cycle as a drop -> `overflow` = 1, `drop_cnt` = 1.
- Assert `rst_async` with 3 entries queued and `evt_in` held high -> all outputs return to reset values. No capture occurs after release until `evt_in` goes low and then high again. With count wrapping 0xFFFF -> 0x0000 between two events, both values are stored raw and in order.
